// File: rtl/seq_det_pkg.sv
// Shared types, defaults and helpers for the programmable serial pattern detector.
package seq_det_pkg;

  localparam int unsigned SEQ_MAX_LEN = 16;
  localparam int unsigned SEQ_LEN_W   = $clog2(SEQ_MAX_LEN + 1);

  typedef logic [SEQ_MAX_LEN-1:0] pat_t;

  typedef enum logic {
    MODE_NOVL = 1'b0,
    MODE_OVL  = 1'b1
  } ovl_mode_e;

  // Low-order mask with 'len' ones; callers cast down to their pattern width.
  function automatic logic [31:0] mask(input int unsigned len);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      m[i] = (i < len);
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_det_hist.sv
// Serial history shift register plus saturating fill counter.
// shift=1 takes x into bit 0 and advances fill toward len; with clr=1 on the
// same edge the history keeps shifting but fill restarts from zero.
// clr=1 without shift empties both history and fill.
module seq_det_hist #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               shift,
  input  logic               x,
  input  logic [LEN_W-1:0]   len,
  output logic [MAX_LEN-1:0] hist,
  output logic [LEN_W-1:0]   fill
);

  // History shift and saturating valid-bit count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= {hist[MAX_LEN-2:0], x};
      fill <= clr ? '0 : ((fill >= len) ? len : fill + 1'b1);
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
    end
  end

endmodule

// File: rtl/seq_detec_prog.sv
// Runtime-programmable serial bit-pattern detector.
// Optional match counter enabled by defining SEQ_DET_CNT_EN.
module seq_detec_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned         MAX_LEN = SEQ_MAX_LEN,
  parameter int unsigned         LEN_W   = $clog2(MAX_LEN + 1),
  parameter logic [MAX_LEN-1:0]  DEF_PAT = MAX_LEN'(16'h0036),
  parameter int unsigned         DEF_LEN = 6,
  parameter bit                  DEF_OVL = 1'b1,
  parameter int unsigned         CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               x_vld,
  input  logic               pat_ld,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               ovl_in,
  output logic               z
`ifdef SEQ_DET_CNT_EN
  ,
  output logic [CNT_W-1:0]   match_cnt
`endif
);

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  ovl_mode_e          r_ovl;
  logic               r_z;

  logic [MAX_LEN-1:0] w_hist;
  logic [LEN_W-1:0]   w_fill;
  logic [LEN_W-1:0]   w_fill_n;
  logic [LEN_W-1:0]   w_len_ld;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_shift;
  logic               w_match;
  logic               w_hit;
  logic               w_clr;

  // A zero or oversized length selects the full pattern width.
  assign w_len_ld = ((len_in == '0) || (len_in > LEN_W'(MAX_LEN))) ? LEN_W'(MAX_LEN) : len_in;

  assign w_mask   = MAX_LEN'(mask(32'(r_len)));
  assign w_shift  = x_vld & ~pat_ld;
  assign w_fill_n = (w_fill >= r_len) ? r_len : w_fill + 1'b1;

  // Compare against the post-shift history; the bit shifted out of the MSB
  // is carried along but always masked off.
  assign w_match  = ({w_hist, x} & {1'b0, w_mask}) == {1'b0, r_pat & w_mask};
  assign w_hit    = w_shift & (w_fill_n == r_len) & w_match;
  assign w_clr    = pat_ld | (w_hit & (r_ovl == MODE_NOVL));

  seq_det_hist #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .shift (w_shift),
    .x     (x),
    .len   (r_len),
    .hist  (w_hist),
    .fill  (w_fill)
  );

  // Pattern configuration registers, reloaded by the load strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pat <= DEF_PAT;
      r_len <= LEN_W'(DEF_LEN);
      r_ovl <= ovl_mode_e'(DEF_OVL);
    end else if (pat_ld) begin
      r_pat <= pat_in;
      r_len <= w_len_ld;
      r_ovl <= ovl_mode_e'(ovl_in);
    end
  end

  // Registered single-cycle match pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_z <= 1'b0;
    end else begin
      r_z <= w_hit;
    end
  end

  assign z = r_z;

`ifdef SEQ_DET_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Saturating match counter, cleared whenever a new pattern is loaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (pat_ld) begin
      r_cnt <= '0;
    end else if (w_hit && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign match_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_seq_detec_prog.sv
// Scoreboard bench for seq_detec_prog: stimulus queues expected z/match_cnt
// per clock edge, a monitor pops and compares just after each edge.
module tb_seq_detec_prog;

  localparam int unsigned ML = 16;
  localparam int unsigned LW = 5;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          x;
  logic          x_vld;
  logic          pat_ld;
  logic [ML-1:0] pat_in;
  logic [LW-1:0] len_in;
  logic          ovl_in;
  logic          z;
`ifdef SEQ_DET_CNT_EN
  logic [CW-1:0] match_cnt;
`endif

  seq_detec_prog #(
    .MAX_LEN (ML),
    .LEN_W   (LW),
    .DEF_PAT (16'h0036),
    .DEF_LEN (6),
    .DEF_OVL (1'b1),
    .CNT_W   (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .x_vld     (x_vld),
    .pat_ld    (pat_ld),
    .pat_in    (pat_in),
    .len_in    (len_in),
    .ovl_in    (ovl_in),
    .z         (z)
`ifdef SEQ_DET_CNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          z;
    logic [CW-1:0] cnt;
    string         nm;
  } exp_t;

  exp_t        q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned ecnt  = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected entry per sampled edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.nm, ".z"}, 8'(z), 8'(e.z));
`ifdef SEQ_DET_CNT_EN
      chk({e.nm, ".cnt"}, 8'(match_cnt), 8'(e.cnt));
`endif
    end
  end

  task automatic push(input logic ez, input string nm);
    exp_t e;
    e.z   = ez;
    e.cnt = ecnt[CW-1:0];
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic send(input logic b, input logic v, input logic ez, input string nm);
    @(posedge clk);
    #2;
    x      = b;
    x_vld  = v;
    pat_ld = 1'b0;
    if (ez && ecnt < 3) ecnt++;
    push(ez, nm);
  endtask

  // Load with x_vld=1 to show the bit on the load edge is discarded.
  task automatic load(input logic [ML-1:0] p, input logic [LW-1:0] l, input logic o, input string nm);
    @(posedge clk);
    #2;
    pat_ld = 1'b1;
    pat_in = p;
    len_in = l;
    ovl_in = o;
    x      = 1'b1;
    x_vld  = 1'b1;
    ecnt   = 0;
    push(1'b0, nm);
  endtask

  // Sends n bits MSB first; zexp bit aligned with each sent bit.
  task automatic run(input logic [31:0] bits, input int unsigned n, input logic [31:0] zexp, input string nm);
    for (int unsigned i = 0; i < n; i++) begin
      send(bits[n-1-i], 1'b1, zexp[n-1-i], nm);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] gap_pat;
    rst    = 1'b1;
    x      = 1'b0;
    x_vld  = 1'b0;
    pat_ld = 1'b0;
    pat_in = '0;
    len_in = '0;
    ovl_in = 1'b0;
    #12;
    rst = 1'b0;
    #1;
    chk("reset.z", 8'(z), 8'h00);
`ifdef SEQ_DET_CNT_EN
    chk("reset.cnt", 8'(match_cnt), 8'h00);
`endif

    // Default overlapping pattern 110110.
    run(32'b110110110, 9, 32'b000001001, "t1_ovl");

    // Non-overlapping: second hit needs six fresh bits.
    load(16'h0036, 5'd6, 1'b0, "t2_ld");
    run(32'b110110110110, 12, 32'b000001000001, "t2_novl");

    // Gapped input: invalid cycles carry the opposite bit and must be ignored.
    load(16'h0036, 5'd6, 1'b1, "t3_ld");
    gap_pat = 6'b110110;
    for (int unsigned i = 0; i < 6; i++) begin
      send(gap_pat[5-i], 1'b1, (i == 5), "t3_gap");
      send(~gap_pat[5-i], 1'b0, 1'b0, "t3_gap");
    end

    // Reload mid-pattern discards the partial 11011.
    load(16'h0036, 5'd6, 1'b1, "t4_ld");
    run(32'b11011, 5, 32'b0, "t4_pre");
    load(16'h000A, 5'd4, 1'b1, "t4_ld2");
    run(32'b01010, 5, 32'b00001, "t4_new");

    // Length clamping: 0 and 20 both select 16.
    load(16'hFFFF, 5'd0, 1'b1, "clamp0_ld");
    run(32'h0001FFFF, 17, 32'b11, "clamp0");
    load(16'h8001, 5'd20, 1'b1, "clamp20_ld");
    run(32'h00008001, 16, 32'b1, "clamp20");

    // Asynchronous reset mid-pattern.
    load(16'h0036, 5'd6, 1'b1, "t5_ld");
    run(32'b11011, 5, 32'b0, "t5_pre");
    @(posedge clk);
    #2;
    x_vld  = 1'b0;
    pat_ld = 1'b0;
    rst    = 1'b1;
    #3;
    rst  = 1'b0;
    ecnt = 0;
    #1;
    chk("t5_rst.z", 8'(z), 8'h00);
`ifdef SEQ_DET_CNT_EN
    chk("t5_rst.cnt", 8'(match_cnt), 8'h00);
`endif
    run(32'b0, 1, 32'b0, "t5_after");
    run(32'b110110, 6, 32'b000001, "t5_fresh");

    // len=1 in both modes, counter saturation at 3.
    load(16'h0001, 5'd1, 1'b0, "t6_ld");
    run(32'b11111, 5, 32'b11111, "t6_len1");
    run(32'b0, 1, 32'b0, "t6_zero");
    load(16'h0001, 5'd1, 1'b1, "t6_clr");
    run(32'b101, 3, 32'b101, "t6_ovl");

    @(posedge clk);
    #2;
    x_vld  = 1'b0;
    pat_ld = 1'b0;
    for (int unsigned i = 0; i < 10 && q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
